// File: rtl/egress_scheduler_pkg.sv
// rtl/egress_scheduler_pkg.sv - shared types and constants for the egress frame scheduler
package egress_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRAME = 2'd1,
        S_DRAIN = 2'd2,
        S_GAP   = 2'd3
    } state_type;

    localparam int BEAT_WIDTH = 9;
    localparam int LAST_BIT   = 8;

    function automatic int wrap_next(input int idx, input int limit);
        return (idx >= limit - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/round_robin_picker.sv
// rtl/round_robin_picker.sv - combinational first-set search starting at pointer, with wrap
module round_robin_picker #(
    parameter int SOURCES = 4,
    parameter int PW      = $clog2(SOURCES)
) (
    input  logic [SOURCES-1:0] request,
    input  logic [PW-1:0]      pointer,
    output logic               found,
    output logic [PW-1:0]      index
);

    int          cand;
    logic [PW-1:0] cand_idx;

    // Scan from farthest to nearest so the nearest requester wins the last write.
    always_comb begin
        found    = 1'b0;
        index    = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = SOURCES - 1; i >= 0; i--) begin
            cand = int'(pointer) + i;
            if (cand >= SOURCES) begin
                cand = cand - SOURCES;
            end
            cand_idx = PW'(cand);
            if (request[cand_idx]) begin
                found = 1'b1;
                index = cand_idx;
            end
        end
    end

endmodule

// File: rtl/egress_frame_scheduler.sv
// rtl/egress_frame_scheduler.sv - frame-granular round-robin egress scheduler with truncation and gap
// Optional per-source frame / truncation statistics: EGRESS_SCHEDULER_STATS_EN.
module egress_frame_scheduler
    import egress_scheduler_pkg::*;
#(
    parameter int SOURCES         = 4,
    parameter int MAX_FRAME_BYTES = 1522,
    parameter int GAP_CYCLES      = 12
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [SOURCES-1:0]            request,
    input  logic [SOURCES*BEAT_WIDTH-1:0] data,
    input  logic [SOURCES-1:0]            data_enable,
    input  logic                          egress_ready,
    output logic [SOURCES-1:0]            grant,
    output logic [BEAT_WIDTH-1:0]         push_data,
    output logic                          push_data_valid,
    output logic                          truncated,
    output logic                          busy
`ifdef EGRESS_SCHEDULER_STATS_EN
    ,
    output logic [SOURCES*32-1:0]         frame_count,
    output logic [31:0]                   truncate_count
`endif
);

    localparam int PW  = $clog2(SOURCES);
    localparam int BCW = $clog2(MAX_FRAME_BYTES + 1);
    localparam int GCW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [BCW-1:0] TRUNC_AT   = BCW'(MAX_FRAME_BYTES - 1);
    localparam logic [GCW-1:0] GAP_LAST   = GCW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam state_type      EXIT_STATE = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

    state_type             state, state_next;
    logic [PW-1:0]         pointer, pointer_next;
    logic [PW-1:0]         sel, sel_next;
    logic [BCW-1:0]        byte_count, byte_count_next;
    logic [GCW-1:0]        gap_count, gap_count_next;
    logic [SOURCES-1:0]    grant_next;
    logic [BEAT_WIDTH-1:0] push_data_next;
    logic                  push_data_valid_next;
    logic                  truncated_next;
    logic                  busy_next;
    logic                  finish_frame;
    logic                  trunc_event;

    logic                  pick_found;
    logic [PW-1:0]         pick_index;

    logic [BEAT_WIDTH-1:0] beat_array [SOURCES];
    logic [BEAT_WIDTH-1:0] cur_beat;
    logic                  cur_enable;
    logic                  cur_last;
    logic [PW-1:0]         sel_wrap;

    for (genvar g = 0; g < SOURCES; g++) begin : g_unpack
        assign beat_array[g] = data[g*BEAT_WIDTH +: BEAT_WIDTH];
    end

    assign cur_beat   = beat_array[sel];
    assign cur_enable = data_enable[sel];
    assign cur_last   = cur_beat[LAST_BIT];
    assign sel_wrap   = PW'(wrap_next(int'(sel), SOURCES));

    round_robin_picker #(
        .SOURCES (SOURCES),
        .PW      (PW)
    ) u_picker (
        .request (request),
        .pointer (pointer),
        .found   (pick_found),
        .index   (pick_index)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= S_IDLE;
            pointer         <= '0;
            sel             <= '0;
            byte_count      <= '0;
            gap_count       <= '0;
            grant           <= '0;
            push_data       <= '0;
            push_data_valid <= 1'b0;
            truncated       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            state           <= state_next;
            pointer         <= pointer_next;
            sel             <= sel_next;
            byte_count      <= byte_count_next;
            gap_count       <= gap_count_next;
            grant           <= grant_next;
            push_data       <= push_data_next;
            push_data_valid <= push_data_valid_next;
            truncated       <= truncated_next;
            busy            <= busy_next;
        end
    end

    always_comb begin
        state_next           = state;
        pointer_next         = pointer;
        sel_next             = sel;
        byte_count_next      = byte_count;
        gap_count_next       = gap_count;
        grant_next           = grant;
        push_data_next       = '0;
        push_data_valid_next = 1'b0;
        truncated_next       = 1'b0;
        finish_frame         = 1'b0;
        trunc_event          = 1'b0;

        case (state)
            S_IDLE: begin
                if (egress_ready && pick_found) begin
                    sel_next               = pick_index;
                    grant_next             = '0;
                    grant_next[pick_index] = 1'b1;
                    byte_count_next        = '0;
                    state_next             = S_FRAME;
                end
            end
            S_FRAME: begin
                if (cur_enable) begin
                    push_data_next       = cur_beat;
                    push_data_valid_next = 1'b1;
                    byte_count_next      = byte_count + 1'b1;
                    if (cur_last) begin
                        finish_frame = 1'b1;
                    end else if (byte_count == TRUNC_AT) begin
                        // Close the frame downstream now; the source's tail is discarded in S_DRAIN.
                        push_data_next[LAST_BIT] = 1'b1;
                        truncated_next           = 1'b1;
                        trunc_event              = 1'b1;
                        state_next               = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (cur_enable && cur_last) begin
                    finish_frame = 1'b1;
                end
            end
            S_GAP: begin
                if (gap_count == GAP_LAST) begin
                    state_next = S_IDLE;
                end else begin
                    gap_count_next = gap_count + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase

        if (finish_frame) begin
            grant_next     = '0;
            pointer_next   = sel_wrap;
            gap_count_next = '0;
            state_next     = EXIT_STATE;
        end

        busy_next = (state_next != S_IDLE);
    end

`ifdef EGRESS_SCHEDULER_STATS_EN
    logic [31:0] frame_cnt [SOURCES];
    logic [31:0] trunc_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SOURCES; i++) begin
                frame_cnt[i] <= '0;
            end
            trunc_cnt <= '0;
        end else begin
            if (finish_frame && (frame_cnt[sel] != 32'hFFFF_FFFF)) begin
                frame_cnt[sel] <= frame_cnt[sel] + 32'd1;
            end
            if (trunc_event && (trunc_cnt != 32'hFFFF_FFFF)) begin
                trunc_cnt <= trunc_cnt + 32'd1;
            end
        end
    end

    for (genvar g = 0; g < SOURCES; g++) begin : g_stats
        assign frame_count[g*32 +: 32] = frame_cnt[g];
    end
    assign truncate_count = trunc_cnt;
`else
    logic unused_stats;
    assign unused_stats = finish_frame ^ trunc_event;
`endif

endmodule

// File: tb/tb_egress_frame_scheduler.sv
// tb/tb_egress_frame_scheduler.sv - self-checking scoreboard bench for egress_frame_scheduler
module tb_egress_frame_scheduler;

    localparam int SRC  = 4;
    localparam int MAXB = 8;
    localparam int GAP  = 12;
    localparam int RR_ORDER [5] = '{0, 1, 2, 3, 0};

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [SRC-1:0]    request = '0;
    logic [SRC*9-1:0]  data = '0;
    logic [SRC-1:0]    data_enable = '0;
    logic              egress_ready = 1'b1;
    logic [SRC-1:0]    grant;
    logic [8:0]        push_data;
    logic              push_data_valid;
    logic              truncated;
    logic              busy;
`ifdef EGRESS_SCHEDULER_STATS_EN
    logic [SRC*32-1:0] frame_count;
    logic [31:0]       truncate_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0] src_q [SRC][$];
    logic [8:0] exp_q [SRC][$];
    bit         bubble_en = 1'b0;

    egress_frame_scheduler #(
        .SOURCES         (SRC),
        .MAX_FRAME_BYTES (MAXB),
        .GAP_CYCLES      (GAP)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .request         (request),
        .data            (data),
        .data_enable     (data_enable),
        .egress_ready    (egress_ready),
        .grant           (grant),
        .push_data       (push_data),
        .push_data_valid (push_data_valid),
        .truncated       (truncated),
        .busy            (busy)
`ifdef EGRESS_SCHEDULER_STATS_EN
        ,
        .frame_count     (frame_count),
        .truncate_count  (truncate_count)
`endif
    );

    always #5 clock = ~clock;

    // Source model: a granted source presents its next queued beat, optionally with bubbles.
    initial begin
        forever begin
            @(negedge clock);
            for (int s = 0; s < SRC; s++) begin
                if (grant[s] && src_q[s].size() > 0 && !(bubble_en && $urandom_range(0, 3) == 0)) begin
                    data[s*9 +: 9] = src_q[s].pop_front();
                    data_enable[s] = 1'b1;
                end else begin
                    data[s*9 +: 9] = 9'($urandom);
                    data_enable[s] = 1'b0;
                end
                request[s] = (src_q[s].size() > 0);
            end
        end
    end

    // Scoreboard: every forwarded beat must match the head of the granted source's queue.
    initial begin
        int         mon_src;
        logic [8:0] e;
        mon_src = 0;
        forever begin
            @(negedge clock);
            for (int s = 0; s < SRC; s++) begin
                if (grant[s]) mon_src = s;
            end
            if (push_data_valid) begin
                checks++;
                if (exp_q[mon_src].size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected src=%0d got=%h expected=none", mon_src, push_data);
                end else begin
                    e = exp_q[mon_src].pop_front();
                    if (push_data !== e) begin
                        errors++;
                        $display("FAIL beat_data src=%0d got=%h expected=%h", mon_src, push_data, e);
                    end
                end
            end
        end
    end

    task automatic load_frame(input int s, input int len);
        for (int b = 0; b < len; b++) begin
            logic [8:0] beat;
            beat = {(b == len - 1), 8'($urandom)};
            src_q[s].push_back(beat);
            if (b < MAXB) begin
                if (b == MAXB - 1) beat[8] = 1'b1;
                exp_q[s].push_back(beat);
            end
        end
    endtask

    task automatic flush_all();
        for (int s = 0; s < SRC; s++) begin
            src_q[s].delete();
            exp_q[s].delete();
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        flush_all();
        repeat (2) @(negedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b expected=0000", grant); end
        checks++;
        if (push_data_valid !== 1'b0 || push_data !== 9'h0) begin
            errors++; $display("FAIL reset_push got=%b/%h expected=0/000", push_data_valid, push_data);
        end
        checks++;
        if (truncated !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_flags got=%b%b expected=00", truncated, busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_frame();
        int t;
        int gap;
        load_frame(2, 5);
        t = 0;
        while (!request[2] && t < 20) begin @(negedge clock); #1; t++; end
        @(negedge clock); #1;
        checks++;
        if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b expected=0100", grant); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got=%b expected=1", busy); end
        t = 0;
        while (grant != 0 && t < 50) begin @(negedge clock); #1; t++; end
        gap = 0;
        t = 0;
        while (busy && t < 50) begin
            if (grant == 0) gap++;
            @(negedge clock); #1; t++;
        end
        checks++;
        if (gap != GAP) begin errors++; $display("FAIL single_gap got=%0d expected=%0d", gap, GAP); end
        checks++;
        if (exp_q[2].size() != 0) begin errors++; $display("FAIL single_drained got=%0d expected=0", exp_q[2].size()); end
    endtask

    task automatic test_round_robin();
        int order [5];
        int when [5];
        int n;
        int cyc;
        int t;
        logic [SRC-1:0] prev;
        apply_reset();
        bubble_en = 1'b1;
        for (int s = 0; s < SRC; s++) load_frame(s, 3);
        load_frame(0, 3);
        n = 0;
        cyc = 0;
        prev = '0;
        while (n < 5 && cyc < 800) begin
            @(negedge clock); #1; cyc++;
            if (grant != 0 && prev == 0) begin
                for (int s = 0; s < SRC; s++) if (grant[s]) order[n] = s;
                when[n] = cyc;
                n++;
            end
            prev = grant;
        end
        checks++;
        if (n != 5) begin errors++; $display("FAIL rr_grant_count got=%0d expected=5", n); end
        for (int i = 0; i < n; i++) begin
            checks++;
            if (order[i] != RR_ORDER[i]) begin
                errors++; $display("FAIL rr_order idx=%0d got=%0d expected=%0d", i, order[i], RR_ORDER[i]);
            end
            if (i > 0) begin
                checks++;
                if (when[i] - when[i-1] < GAP + 2) begin
                    errors++; $display("FAIL rr_spacing idx=%0d got=%0d expected>=%0d", i, when[i] - when[i-1], GAP + 2);
                end
            end
        end
        t = 0;
        while ((request != 0 || busy) && t < 300) begin @(negedge clock); #1; t++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_timeout got=%b expected=0", busy); end
        bubble_en = 1'b0;
    endtask

    task automatic test_truncation();
        int valids;
        int truncs;
        int bad;
        int t;
        bit started;
        bubble_en = 1'b1;
        load_frame(1, 12);
        valids = 0; truncs = 0; bad = 0; t = 0; started = 1'b0;
        while (!(started && !busy) && t < 300) begin
            @(negedge clock); #1; t++;
            if (grant != 0) started = 1'b1;
            if (push_data_valid) valids++;
            if (truncated) begin
                truncs++;
                if (!push_data_valid || !push_data[8]) bad++;
            end
        end
        checks++;
        if (valids != MAXB) begin errors++; $display("FAIL trunc_beats got=%0d expected=%0d", valids, MAXB); end
        checks++;
        if (truncs != 1) begin errors++; $display("FAIL trunc_pulses got=%0d expected=1", truncs); end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL trunc_alignment got=%0d expected=0", bad); end
        checks++;
        if (src_q[1].size() != 0) begin errors++; $display("FAIL trunc_drain got=%0d expected=0", src_q[1].size()); end
        bubble_en = 1'b0;
    endtask

    task automatic test_egress_ready();
        int ng;
        int t;
        egress_ready = 1'b0;
        load_frame(0, 3);
        ng = 0;
        repeat (10) begin
            @(negedge clock); #1;
            if (grant != 0 || busy) ng++;
        end
        checks++;
        if (ng != 0) begin errors++; $display("FAIL ready_hold got=%0d expected=0", ng); end
        egress_ready = 1'b1;
        @(negedge clock); #1;
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("FAIL ready_grant got=%b expected=0001", grant); end
        t = 0;
        while ((request != 0 || busy) && t < 200) begin @(negedge clock); #1; t++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ready_idle_timeout got=%b expected=0", busy); end
    endtask

    task automatic test_reset_mid_frame();
        int valids;
        int t;
        load_frame(1, 6);
        valids = 0; t = 0;
        while (valids < 3 && t < 100) begin
            @(negedge clock); #1; t++;
            if (push_data_valid) valids++;
        end
        checks++;
        if (valids != 3) begin errors++; $display("FAIL midreset_reach got=%0d expected=3", valids); end
        reset = 1'b1;
        @(negedge clock); #1;
        checks++;
        if (grant !== 4'b0000 || push_data_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midreset_outputs got=%b/%b/%b expected=0000/0/0", grant, push_data_valid, busy);
        end
        flush_all();
        @(negedge clock); #1;
        reset = 1'b0;
        load_frame(0, 2);
        load_frame(3, 2);
        t = 0;
        while (grant == 0 && t < 50) begin @(negedge clock); #1; t++; end
        checks++;
        if (grant !== 4'b0001) begin errors++; $display("FAIL midreset_pointer got=%b expected=0001", grant); end
        t = 0;
        while ((request != 0 || busy) && t < 300) begin @(negedge clock); #1; t++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_idle_timeout got=%b expected=0", busy); end
    endtask

`ifdef EGRESS_SCHEDULER_STATS_EN
    task automatic test_stats();
        int t;
        apply_reset();
        load_frame(3, 4);
        load_frame(3, 12);
        load_frame(3, 4);
        repeat (2) @(negedge clock);
        #1;
        t = 0;
        while ((request != 0 || busy) && t < 400) begin @(negedge clock); #1; t++; end
        checks++;
        if (frame_count[3*32 +: 32] !== 32'd3) begin
            errors++; $display("FAIL stats_frames got=%0d expected=3", frame_count[3*32 +: 32]);
        end
        checks++;
        if (truncate_count !== 32'd1) begin errors++; $display("FAIL stats_truncs got=%0d expected=1", truncate_count); end
        checks++;
        if (frame_count[31:0] !== 32'd0) begin errors++; $display("FAIL stats_other got=%0d expected=0", frame_count[31:0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_round_robin();
        test_truncation();
        test_egress_ready();
        test_reset_mid_frame();
`ifdef EGRESS_SCHEDULER_STATS_EN
        test_stats();
`endif
        repeat (3) @(negedge clock);
        #1;
        for (int s = 0; s < SRC; s++) begin
            checks++;
            if (exp_q[s].size() != 0) begin
                errors++; $display("FAIL leftover_beats src=%0d got=%0d expected=0", s, exp_q[s].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
